// File: rtl/a_defines.sv
// Shared types for the issue-queue slice: ROB tags, data words and the
// per-operand source record held in each queue entry.
package a_defines;
  localparam int ROB_ID_W = 6;
  localparam int WORD_W   = 32;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [WORD_W-1:0]   word_t;

  typedef struct packed {
    rob_id_t tag;
    logic    ready;
    word_t   data;
  } iq_src_t;
endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker for the issue queue; grants the oldest requesting entry.
// r_age[i][j] = 1 means entry i is older than entry j.
module iq_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);
  logic [N-1:0][N-1:0] r_age;

  // Same-cycle allocations land in ascending entry order by port, so the
  // lower entry index is the older one among them.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i_alloc[i])
            r_age[i][j] <= i_alloc[j] && (j > i);
          else if (i_alloc[j])
            r_age[i][j] <= 1'b1;
          else if (i_free[i] || i_free[j])
            r_age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < N; j++)
        if (j != i && i_req[j] && r_age[j][i]) o_grant[i] = 1'b0;
    end
  end
endmodule

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: multi-port dispatch, CDB wakeup, oldest-ready
// select into a single registered issue slot.
module age_issue_queue
  import a_defines::*;
#(
  parameter int IQ_SIZE      = 8,
  parameter int DISPATCH_CNT = 2,
  parameter int SRC_COUNT    = 2,
  parameter int CDB_COUNT    = 2,
  parameter int PAYLOAD_W    = 64
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       flush,
  input  logic    [DISPATCH_CNT-1:0]                 disp_valid_i,
  input  logic    [DISPATCH_CNT-1:0][PAYLOAD_W-1:0]  disp_payload_i,
  input  rob_id_t [DISPATCH_CNT-1:0][SRC_COUNT-1:0]  disp_src_tag_i,
  input  logic    [DISPATCH_CNT-1:0][SRC_COUNT-1:0]  disp_src_rdy_i,
  input  word_t   [DISPATCH_CNT-1:0][SRC_COUNT-1:0]  disp_src_data_i,
  output logic                                       disp_ready_o,
  output logic    [$clog2(IQ_SIZE+1)-1:0]            free_cnt_o,
  input  logic    [CDB_COUNT-1:0]                    cdb_valid_i,
  input  rob_id_t [CDB_COUNT-1:0]                    cdb_tag_i,
  input  word_t   [CDB_COUNT-1:0]                    cdb_data_i,
  output logic                                       issue_valid_o,
  input  logic                                       issue_ready_i,
  output logic    [PAYLOAD_W-1:0]                    issue_payload_o,
  output word_t   [SRC_COUNT-1:0]                    issue_data_o
);
  localparam int CNT_W = $clog2(IQ_SIZE+1);

  logic    [IQ_SIZE-1:0]                 r_occ;
  logic    [IQ_SIZE-1:0][PAYLOAD_W-1:0]  r_payload;
  iq_src_t [IQ_SIZE-1:0][SRC_COUNT-1:0]  r_src;
  logic    [CNT_W-1:0]                   r_free_cnt;
  logic                                  r_disp_ready;
  logic                                  r_issue_valid;
  logic    [PAYLOAD_W-1:0]               r_issue_payload;
  word_t   [SRC_COUNT-1:0]               r_issue_data;

  logic    [IQ_SIZE-1:0]                     w_alloc, w_elig, w_req, w_grant;
  logic    [DISPATCH_CNT-1:0][IQ_SIZE-1:0]   w_port_slot;
  iq_src_t [DISPATCH_CNT-1:0][SRC_COUNT-1:0] w_disp_src;
  iq_src_t [IQ_SIZE-1:0][SRC_COUNT-1:0]      w_wake_src;
  logic                                      w_can_issue, w_issue;
  logic    [PAYLOAD_W-1:0]                   w_sel_payload;
  word_t   [SRC_COUNT-1:0]                   w_sel_data;
  int                                        w_free_nxt;

  // Descending scan so the lowest matching channel has the final say.
  function automatic iq_src_t cdb_capture(iq_src_t src,
                                          logic    [CDB_COUNT-1:0] v,
                                          rob_id_t [CDB_COUNT-1:0] t,
                                          word_t   [CDB_COUNT-1:0] d);
    iq_src_t res;
    res = src;
    for (int c = CDB_COUNT-1; c >= 0; c--)
      if (!src.ready && v[c] && t[c] == src.tag) begin
        res.ready = 1'b1;
        res.data  = d[c];
      end
    return res;
  endfunction

  // Only entries empty at the start of the cycle are allocatable, so a slot
  // freed by this cycle's issue is reused one cycle later.
  always_comb begin
    logic found;
    w_alloc     = '0;
    w_port_slot = '0;
    for (int p = 0; p < DISPATCH_CNT; p++) begin
      found = 1'b0;
      if (disp_valid_i[p] && r_disp_ready)
        for (int e = 0; e < IQ_SIZE; e++)
          if (!found && !r_occ[e] && !w_alloc[e]) begin
            w_port_slot[p][e] = 1'b1;
            w_alloc[e]        = 1'b1;
            found             = 1'b1;
          end
    end
  end

  always_comb begin
    for (int p = 0; p < DISPATCH_CNT; p++)
      for (int s = 0; s < SRC_COUNT; s++)
        w_disp_src[p][s] = cdb_capture(iq_src_t'{tag: disp_src_tag_i[p][s],
                                                 ready: disp_src_rdy_i[p][s],
                                                 data: disp_src_data_i[p][s]},
                                       cdb_valid_i, cdb_tag_i, cdb_data_i);
    for (int e = 0; e < IQ_SIZE; e++)
      for (int s = 0; s < SRC_COUNT; s++)
        w_wake_src[e][s] = cdb_capture(r_src[e][s], cdb_valid_i, cdb_tag_i, cdb_data_i);
  end

  always_comb begin
    for (int e = 0; e < IQ_SIZE; e++) begin
      w_elig[e] = r_occ[e];
      for (int s = 0; s < SRC_COUNT; s++) w_elig[e] = w_elig[e] & r_src[e][s].ready;
    end
  end

  assign w_can_issue = !r_issue_valid || issue_ready_i;
  assign w_req       = w_elig & {IQ_SIZE{w_can_issue}};
  assign w_issue     = |w_grant;

  iq_age_matrix #(.N(IQ_SIZE)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .i_alloc (w_alloc),
    .i_free  (w_grant),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_sel_payload = '0;
    w_sel_data    = '0;
    for (int e = 0; e < IQ_SIZE; e++)
      if (w_grant[e]) begin
        w_sel_payload = w_sel_payload | r_payload[e];
        for (int s = 0; s < SRC_COUNT; s++) w_sel_data[s] = w_sel_data[s] | r_src[e][s].data;
      end
  end

  assign w_free_nxt = int'(r_free_cnt) - $countones(w_alloc) + int'(w_issue);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_occ           <= '0;
      r_payload       <= '0;
      r_src           <= '0;
      r_free_cnt      <= CNT_W'(IQ_SIZE);
      r_disp_ready    <= 1'b1;
      r_issue_valid   <= 1'b0;
      r_issue_payload <= '0;
      r_issue_data    <= '0;
    end else begin
      r_occ        <= (r_occ & ~w_grant) | w_alloc;
      r_free_cnt   <= CNT_W'(w_free_nxt);
      r_disp_ready <= (w_free_nxt >= DISPATCH_CNT);
      for (int e = 0; e < IQ_SIZE; e++) begin
        r_src[e] <= w_wake_src[e];
        for (int p = 0; p < DISPATCH_CNT; p++)
          if (w_port_slot[p][e]) begin
            r_payload[e] <= disp_payload_i[p];
            r_src[e]     <= w_disp_src[p];
          end
      end
      if (w_issue) begin
        r_issue_valid   <= 1'b1;
        r_issue_payload <= w_sel_payload;
        r_issue_data    <= w_sel_data;
      end else if (issue_ready_i) begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  assign disp_ready_o    = r_disp_ready;
  assign free_cnt_o      = r_free_cnt;
  assign issue_valid_o   = r_issue_valid;
  assign issue_payload_o = r_issue_payload;
  assign issue_data_o    = r_issue_data;
endmodule

// File: tb/tb_age_issue_queue.sv
// Scoreboard bench for age_issue_queue: a queue-based reference model predicts
// issues; a negedge monitor compares them and the occupancy outputs.
module tb_age_issue_queue;
  import a_defines::*;

  localparam int IQ = 4, DC = 2, SC = 2, CC = 2, PW = 16;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic    [DC-1:0]         disp_valid;
  logic    [DC-1:0][PW-1:0] disp_payload;
  rob_id_t [DC-1:0][SC-1:0] disp_tag;
  logic    [DC-1:0][SC-1:0] disp_rdy;
  word_t   [DC-1:0][SC-1:0] disp_data;
  logic                     disp_ready;
  logic    [2:0]            free_cnt;
  logic    [CC-1:0]         cdb_valid;
  rob_id_t [CC-1:0]         cdb_tag;
  word_t   [CC-1:0]         cdb_data;
  logic                     issue_valid, issue_ready;
  logic    [PW-1:0]         issue_payload;
  word_t   [SC-1:0]         issue_data;

  typedef struct packed {
    logic    [PW-1:0] pl;
    logic    [SC-1:0] rdy;
    rob_id_t [SC-1:0] tag;
    word_t   [SC-1:0] data;
  } ment_t;
  typedef struct packed {
    logic  [PW-1:0] pl;
    word_t [SC-1:0] data;
  } exp_t;

  ment_t mq[$];
  exp_t  exp_q[$];
  logic  m_out_valid = 1'b0, m_disp_ready = 1'b1;
  bit    mon_en = 1'b0;
  int    n_cmp = 0, n_bad = 0, pl_seq = 0;

  age_issue_queue #(.IQ_SIZE(IQ), .DISPATCH_CNT(DC), .SRC_COUNT(SC),
                    .CDB_COUNT(CC), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid_i(disp_valid), .disp_payload_i(disp_payload),
    .disp_src_tag_i(disp_tag), .disp_src_rdy_i(disp_rdy), .disp_src_data_i(disp_data),
    .disp_ready_o(disp_ready), .free_cnt_o(free_cnt),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_payload_o(issue_payload), .issue_data_o(issue_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lowest channel wins: the first match sets rdy, so later channels are ignored.
  function automatic ment_t wake(ment_t e);
    for (int s = 0; s < SC; s++)
      for (int c = 0; c < CC; c++)
        if (!e.rdy[s] && cdb_valid[c] && cdb_tag[c] == e.tag[s]) begin
          e.rdy[s]  = 1'b1;
          e.data[s] = cdb_data[c];
        end
    return e;
  endfunction

  // Reference model: entries kept in a list ordered oldest first.
  always @(posedge clk) begin
    int    sel;
    ment_t ne;
    if (!rst_n || flush) begin
      mq.delete();
      exp_q.delete();
      m_out_valid  = 1'b0;
      m_disp_ready = 1'b1;
    end else begin
      sel = -1;
      if (!m_out_valid || issue_ready)
        for (int i = 0; i < mq.size(); i++)
          if (sel < 0 && (&mq[i].rdy)) sel = i;
      if (m_out_valid && issue_ready) m_out_valid = 1'b0;
      if (sel >= 0) begin
        exp_q.push_back(exp_t'{pl: mq[sel].pl, data: mq[sel].data});
        m_out_valid = 1'b1;
        mq.delete(sel);
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (m_disp_ready)
        for (int p = 0; p < DC; p++)
          if (disp_valid[p]) begin
            ne.pl   = disp_payload[p];
            ne.rdy  = disp_rdy[p];
            ne.tag  = disp_tag[p];
            ne.data = disp_data[p];
            mq.push_back(wake(ne));
          end
      m_disp_ready = ((IQ - mq.size()) >= DC);
    end
  end

  // Monitor: the front of exp_q is whatever the issue slot must currently show.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("issue_valid", 64'(issue_valid), 64'(m_out_valid));
      chk("free_cnt", 64'(free_cnt), 64'(IQ - mq.size()));
      chk("disp_ready", 64'(disp_ready), 64'(m_disp_ready));
      if (issue_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got payload %0h expected none", issue_payload);
        end else begin
          chk("issue_payload", 64'(issue_payload), 64'(exp_q[0].pl));
          chk("issue_data", 64'(issue_data), 64'(exp_q[0].data));
          if (issue_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle();
    disp_valid = '0; disp_payload = '0; disp_tag = '0; disp_rdy = '0; disp_data = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    disp_valid = '0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [PW-1:0] pl,
                          input int t0, input logic r0, input word_t d0,
                          input int t1, input logic r1, input word_t d1);
    disp_valid[p]   = 1'b1;
    disp_payload[p] = pl;
    disp_tag[p][0]  = rob_id_t'(t0); disp_rdy[p][0] = r0; disp_data[p][0] = d0;
    disp_tag[p][1]  = rob_id_t'(t1); disp_rdy[p][1] = r1; disp_data[p][1] = d1;
  endtask

  task automatic cdb(input int c, input int t, input word_t d);
    cdb_valid[c] = 1'b1;
    cdb_tag[c]   = rob_id_t'(t);
    cdb_data[c]  = d;
  endtask

  initial begin
    idle();
    issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_free", 64'(free_cnt), 64'(IQ));
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_valid", 64'(issue_valid), 64'd0);
    chk("reset_payload", 64'(issue_payload), 64'd0);
    chk("reset_data", 64'(issue_data), 64'd0);

    // Four ready ops must issue in dispatch order.
    issue_ready = 1'b1;
    set_port(0, 16'h0101, 0, 1, 32'hA1, 0, 1, 32'hB1);
    set_port(1, 16'h0102, 0, 1, 32'hA2, 0, 1, 32'hB2);
    step();
    set_port(0, 16'h0103, 0, 1, 32'hA3, 0, 1, 32'hB3);
    set_port(1, 16'h0104, 0, 1, 32'hA4, 0, 1, 32'hB4);
    step();
    repeat (6) step();
    @(negedge clk);
    chk("drain_free", 64'(free_cnt), 64'(IQ));

    // Older op waiting on tag 5 is overtaken by a younger ready op.
    set_port(0, 16'h0201, 5, 1'b0, 32'h0, 1, 1'b1, 32'h11);
    step();
    set_port(0, 16'h0202, 2, 1'b1, 32'h22, 3, 1'b1, 32'h33);
    step();
    repeat (3) step();
    cdb(0, 5, 32'h1234);
    step();
    repeat (4) step();

    // Same-cycle CDB capture at dispatch, using only the upper port.
    set_port(1, 16'h0301, 7, 1'b0, 32'h0, 2, 1'b1, 32'h22);
    cdb(1, 7, 32'hBEEF);
    step();
    repeat (5) step();

    // Fill while the consumer stalls; a third dispatch must be refused.
    issue_ready = 1'b0;
    set_port(0, 16'h0401, 0, 1, 32'h41, 0, 1, 32'h42);
    set_port(1, 16'h0402, 0, 1, 32'h43, 0, 1, 32'h44);
    step();
    set_port(0, 16'h0403, 0, 1, 32'h45, 0, 1, 32'h46);
    set_port(1, 16'h0404, 0, 1, 32'h47, 0, 1, 32'h48);
    step();
    set_port(0, 16'h04FF, 0, 1, 32'hFF, 0, 1, 32'hFF);
    step();
    repeat (4) step();
    @(negedge clk);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    issue_ready = 1'b1;
    repeat (6) step();

    // Dispatch landing in the same cycle as an issue.
    set_port(0, 16'h0501, 0, 1, 32'h51, 0, 1, 32'h52);
    set_port(1, 16'h0502, 0, 1, 32'h53, 0, 1, 32'h54);
    step();
    set_port(0, 16'h0503, 0, 1, 32'h55, 0, 1, 32'h56);
    step();
    repeat (5) step();

    // Flush with three entries held and the issue slot full.
    issue_ready = 1'b0;
    set_port(0, 16'h0601, 0, 1, 32'h61, 0, 1, 32'h62);
    set_port(1, 16'h0602, 0, 1, 32'h63, 0, 1, 32'h64);
    step();
    set_port(0, 16'h0603, 0, 1, 32'h65, 0, 1, 32'h66);
    set_port(1, 16'h0604, 0, 1, 32'h67, 0, 1, 32'h68);
    step();
    @(negedge clk);
    chk("preflush_free", 64'(free_cnt), 64'd1);
    chk("preflush_valid", 64'(issue_valid), 64'd1);
    flush = 1'b1;
    step();
    @(negedge clk);
    chk("flush_valid", 64'(issue_valid), 64'd0);
    chk("flush_free", 64'(free_cnt), 64'(IQ));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      disp_valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < DC; p++) begin
        disp_payload[p] = PW'(pl_seq);
        pl_seq++;
        for (int s = 0; s < SC; s++) begin
          disp_tag[p][s]  = rob_id_t'($urandom_range(0, 15));
          disp_rdy[p][s]  = 1'($urandom_range(0, 1));
          disp_data[p][s] = word_t'($urandom);
        end
      end
      for (int c = 0; c < CC; c++) begin
        cdb_valid[c] = 1'($urandom_range(0, 1));
        cdb_tag[c]   = rob_id_t'($urandom_range(0, 15));
        cdb_data[c]  = word_t'($urandom);
      end
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 63) == 0);
      step();
    end

    // Drain: broadcast every tag so any pending op can complete.
    issue_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      cdb(0, (2 * n) % 16, word_t'($urandom));
      cdb(1, (2 * n + 1) % 16, word_t'($urandom));
      step();
    end
    repeat (3) step();
    @(negedge clk);
    chk("final_free", 64'(free_cnt), 64'(IQ));
    chk("final_valid", 64'(issue_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/age_issue_queue.md
AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

Interface
REQ-001 Parameter IQ_SIZE, default 8: entry count; any integer 2..16.
REQ-002 Parameter DISPATCH_CNT, default 2: dispatch ports per cycle, 1..IQ_SIZE.
REQ-003 Parameter SRC_COUNT, default 2: source operands per entry.
REQ-004 Parameter CDB_COUNT, default 2: result broadcast channels.
REQ-005 Parameter PAYLOAD_W, default 64: opaque per-instruction payload width, carried unchanged.
REQ-006 clk  in  1  clock; one clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 flush  in  1  synchronous pipeline flush; same effect as reset.
REQ-009 disp_valid_i  in  DISPATCH_CNT  per-port dispatch request.
REQ-010 disp_payload_i  in  DISPATCH_CNT x PAYLOAD_W  payload.
REQ-011 disp_src_tag_i  in  DISPATCH_CNT x SRC_COUNT x rob_id_t  source tags.
REQ-012 disp_src_rdy_i  in  DISPATCH_CNT x SRC_COUNT  source data already valid.
REQ-013 disp_src_data_i  in  DISPATCH_CNT x SRC_COUNT x word_t  source data.
REQ-014 disp_ready_o  out  1  registered; free entries >= DISPATCH_CNT.
REQ-015 free_cnt_o  out  clog2(IQ_SIZE+1)  registered free-entry count.
REQ-016 cdb_valid_i / cdb_tag_i / cdb_data_i  in  CDB_COUNT x (1 / rob_id_t / word_t)  wakeup broadcast.
REQ-017 issue_valid_o  out  1  output register holds an issued instruction.
REQ-018 issue_ready_i  in  1  consumer accepts when valid and ready both high.
REQ-019 issue_payload_o / issue_data_o  out  PAYLOAD_W / SRC_COUNT x word_t  issued instruction, operands.

Function
REQ-020 Dispatch: the port set is accepted only when disp_ready_o=1; each valid port (lowest index first) fills the lowest-index empty entry; ports need not be contiguous.
REQ-021 At dispatch, a source with disp_src_rdy_i=0 whose tag matches a valid CDB channel that cycle SHALL be captured as ready with that CDB data.
REQ-022 Each cycle, every occupied not-ready source matching a valid CDB tag SHALL latch the data and set ready; on multiple matching channels, lowest channel index wins.
REQ-023 Entry is issue-eligible when occupied and all SRC_COUNT sources ready; eligibility uses registered source state (CDB hit becomes eligible next cycle).
REQ-024 Age ordering: an IQ_SIZE x IQ_SIZE age matrix; a newly written entry is younger than all occupied entries; among same-cycle dispatches, lower port is older.
REQ-025 Select: oldest eligible entry, one per cycle, only when output register is empty or being drained (issue_valid_o=0 or issue_ready_i=1).
REQ-026 Selected entry's payload and sources load the output register next edge; the entry frees the same edge; select-to-issue_valid_o latency 1 cycle, dispatch-to-issue minimum 2 cycles.
REQ-027 Output register holds stable while issue_valid_o=1 and issue_ready_i=0.
REQ-028 free count next = current - accepted dispatches + selected issue; simultaneous dispatch and issue both take effect; a freed entry is reusable from the next cycle, not the same cycle.
REQ-029 Full (free=0): disp_ready_o=0, no writes; empty: issue_valid_o falls after last handshake.
REQ-030 free count never below 0 or above IQ_SIZE.

Reset
REQ-031 On rst_n=0 or flush=1: all entries empty, age matrix cleared, issue_valid_o=0, free_cnt_o=IQ_SIZE, disp_ready_o=1 on next cycle; payload/data outputs 0.
REQ-032 Reset or flush mid-operation discards in-flight dispatch, CDB captures and any unaccepted issue_valid_o instruction.

Structure
REQ-033 rob_id_t, word_t and a iq_src_t struct (tag, ready, data) SHALL live in the shared a_defines package.
REQ-034 One sub-module, iq_age_matrix (update on allocate/free, oldest-eligible one-hot select), SHALL be instantiated.

Verification
REQ-035 IQ_SIZE=4: dispatch 4 ready ops, issue_ready_i=1 -> issued in dispatch order, one per cycle, free_cnt_o returns to 4.
REQ-036 Dispatch A(tag 5 pending), then B ready -> B issues first; CDB tag 5 data 0x1234 -> A issues 2 cycles later with operand 0x1234.
REQ-037 Fill to full, hold issue_ready_i=0 -> disp_ready_o=0, issue_payload_o stable; release -> one issue per cycle.
REQ-038 CDB tag 7 in same cycle as dispatch with src tag 7 not ready -> operand captured, issues without further broadcast.
REQ-039 Dispatch and issue in same cycle at free=1 -> free count unchanged, no overflow.
REQ-040 flush with 3 entries occupied and issue_valid_o=1 -> next cycle issue_valid_o=0, free_cnt_o=IQ_SIZE.
